offset_adder_pipe: RTL and testbench

Multi-channel, parametrised successor to the single-channel registered "+5" datapath block. It accepts unsigned samples tagged with a channel number and adds a per-channel, run-time programmable signed offset. The result is either wrapped or saturated, and leaves through a two-stage valid/ready pipeline. It sits between the input sample interface and downstream consumers, and reports overflow per sample plus a running overflow count.

---
 rtl/offset_adder_pipe.sv | 138 +++++++++++++
 tb/tb_offset_adder_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/offset_adder_pipe.sv
// rtl/offset_adder_pipe.sv - per-channel signed offset adder with wrap/saturate and a two-stage valid/ready pipeline
module offset_adder_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int OFFSET   = 5,
  parameter int CNT_W    = 16,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_ch,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sat_en,
  input  logic             cfg_we,
  input  logic [CW-1:0]    cfg_ch,
  input  logic [WIDTH-1:0] cfg_offset,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_ch,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam logic [CW:0] CH_LIMIT = (CW+1)'(CHANNELS);

  logic [WIDTH-1:0] offs_q [CHANNELS];
  logic [WIDTH-1:0] offs_d [CHANNELS];

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic [CW-1:0]    s1_ch_q,    s1_ch_d;
  logic             s1_sat_q,   s1_sat_d;
  logic [WIDTH-1:0] s1_off_q,   s1_off_d;

  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    out_ch_q,    out_ch_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_ovf_q,   out_ovf_d;
  logic [CNT_W-1:0] ovf_cnt_q,   ovf_cnt_d;

  logic                    s2_load;
  logic [CW-1:0]           in_sel;
  logic signed [WIDTH+1:0] sum;
  logic                    sum_neg;
  logic                    sum_big;

  assign s2_load  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  // Out-of-range channel tags fall back to channel 0's offset.
  assign in_sel   = ({1'b0, in_ch} < CH_LIMIT) ? in_ch : '0;

  // Two guard bits hold every data+offset combination without loss.
  assign sum     = $signed({2'b00, s1_data_q}) + $signed({{2{s1_off_q[WIDTH-1]}}, s1_off_q});
  assign sum_neg = sum[WIDTH+1];
  assign sum_big = !sum[WIDTH+1] && sum[WIDTH];

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) offs_d[i] = offs_q[i];
    if (cfg_we && ({1'b0, cfg_ch} < CH_LIMIT)) offs_d[cfg_ch] = cfg_offset;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_ch_d    = s1_ch_q;
    s1_sat_d   = s1_sat_q;
    s1_off_d   = s1_off_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_ch_d   = in_ch;
        s1_sat_d  = sat_en;
        s1_off_d  = offs_q[in_sel];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_ch_d  = s1_ch_q;
        out_ovf_d = sum_neg || sum_big;
        if (s1_sat_q && sum_neg)      out_data_d = '0;
        else if (s1_sat_q && sum_big) out_data_d = '1;
        else                          out_data_d = sum[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (out_valid_q && out_ready && out_ovf_q && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) offs_q[i] <= WIDTH'(OFFSET);
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_ch_q     <= '0;
      s1_sat_q    <= 1'b0;
      s1_off_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) offs_q[i] <= offs_d[i];
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_ch_q     <= s1_ch_d;
      s1_sat_q    <= s1_sat_d;
      s1_off_q    <= s1_off_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_offset_adder_pipe.sv
// tb/tb_offset_adder_pipe.sv - scoreboard bench for offset_adder_pipe
module tb_offset_adder_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_ch = '0;
  logic [7:0] in_data = '0;
  logic       sat_en = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_offset = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] out_ch;
  logic [7:0] out_data;
  logic       out_ovf;
  logic [15:0] ovf_cnt;

  offset_adder_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data), .sat_en(sat_en),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_offset(cfg_offset),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
    .out_ovf(out_ovf), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   evals = 0;
  int   fails = 0;
  int   model_off [4];
  int   model_cnt = 0;
  int   pops = 0;
  logic prev_stall = 1'b0;
  logic [1:0] prev_ch;
  logic [7:0] prev_data;
  logic       prev_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evals++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] ch, input logic [7:0] d, input logic sat, input int off);
    exp_t e;
    int s;
    s = int'(d) + off;
    e.ch  = ch;
    e.ovf = (s < 0) || (s > 255);
    if (sat && s < 0)        e.data = 8'd0;
    else if (sat && s > 255) e.data = 8'd255;
    else                     e.data = 8'(s & 255);
    return e;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 4; i++) model_off[i] = 5;
    model_cnt  = 0;
    prev_stall = 1'b0;
    sb.delete();
  endtask

  // One clock: sample DUT mid-cycle, update scoreboard/model, then advance past the edge.
  task automatic cycle();
    exp_t e;
    #2;
    check("ovf_cnt", 32'(ovf_cnt), 32'(model_cnt));
    if (prev_stall) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'(prev_data));
      check("stall_ch", 32'(out_ch), 32'(prev_ch));
      check("stall_ovf", 32'(out_ovf), 32'(prev_ovf));
    end
    if (out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_ch", 32'(out_ch), 32'(e.ch));
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_ovf", 32'(out_ovf), 32'(e.ovf));
        if (e.ovf && model_cnt < 65535) model_cnt++;
      end
      pops++;
    end
    if (in_valid && in_ready) sb.push_back(model(in_ch, in_data, sat_en, model_off[in_ch]));
    if (cfg_we) model_off[cfg_ch] = int'($signed(cfg_offset));
    prev_stall = out_valid && !out_ready;
    prev_ch    = out_ch;
    prev_data  = out_data;
    prev_ovf   = out_ovf;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] ch, input logic [7:0] d, input logic sat);
    in_valid = 1'b1; in_ch = ch; in_data = d; sat_en = sat;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [7:0] off);
    cfg_we = 1'b1; cfg_ch = ch; cfg_offset = off;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((sb.size() > 0 || out_valid) && n < 50) begin
      cycle();
      n++;
    end
    check("drain_done", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset_model();
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Reset offset, latency of two edges from acceptance.
    beat(2'd0, 8'd10, 1'b0);
    check("lat_not_yet", 32'(out_valid), 32'd0);
    cycle();
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data", 32'(out_data), 32'd15);
    drain();

    // Wrap versus saturate.
    cfg(2'd1, 8'd100);
    cfg(2'd2, 8'hEC);
    beat(2'd1, 8'd200, 1'b0);
    beat(2'd1, 8'd200, 1'b1);
    beat(2'd2, 8'd5, 1'b0);
    beat(2'd2, 8'd5, 1'b1);
    drain();
    check("ovf_cnt_4", 32'(ovf_cnt), 32'd4);

    // Streaming 16 back-to-back beats.
    pops = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_ch = 2'(i); in_data = 8'(i * 17); sat_en = i[2];
      #2;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      if (i >= 2) check("stream_out_valid", 32'(out_valid), 32'd1);
      #(-0);
      cycle();
    end
    in_valid = 1'b0;
    drain();
    check("stream_pops", 32'(pops), 32'd16);

    // Backpressure mid-stream.
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_ch = 2'(i + 1); in_data = 8'(250 - i * 9); sat_en = i[0];
      out_ready = !(i >= 3 && i < 8);
      cycle();
      if (i == 7) begin
        #2;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
    end
    in_valid = 1'b0;
    drain();

    // Config write colliding with a beat on the same channel.
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_offset = 8'hFF;
    beat(2'd3, 8'd7, 1'b0);
    cfg_we = 1'b0;
    beat(2'd3, 8'd7, 1'b0);
    drain();

    // Asynchronous reset with two samples in flight.
    out_ready = 1'b0;
    beat(2'd1, 8'd1, 1'b0);
    beat(2'd1, 8'd2, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    reset_model();
    #3;
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    beat(2'd1, 8'd0, 1'b0);
    cycle();
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_data", 32'(out_data), 32'd5);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
